// File: rtl/or_n_way_pipe.sv
// -----------------------------------------------------------------------------
// or_n_way_pipe
//   Pipelined N-input OR reduction tree with valid tracking and an optional
//   sticky (accumulate-until-clear) output. Each tree level is registered, so
//   a word presented with in_valid reaches o / out_valid LEVELS edges later
//   (counting the sampling edge). Throughput is one word per cycle.
//
// Parameters
//   WIDTH      number of input bits (2..1024)
//   LEVELS     derived: ceil(log2(WIDTH)), tree and pipeline depth
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   in_valid   i is sampled into level 1 this cycle
//   i          data word to reduce
//   sticky     1: o accumulates OR of results; 0: each result replaces o
//   clr        synchronous clear of o, wins over an arriving result
//   o          registered reduction result
//   out_valid  one-cycle pulse per accepted word, in order
// -----------------------------------------------------------------------------
module or_n_way_pipe #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] i,
   input  logic             sticky,
   input  logic             clr,
   output logic             o,
   output logic             out_valid
);

   localparam int LEVELS = $clog2(WIDTH);
   localparam int PW     = 1 << LEVELS;   // padded width, a power of two

   // Zero padding up to the next power of two; pad bits never set the result.
   logic [PW-1:0] w_pad;
   assign w_pad = PW'(i);

   // Tree levels 1..LEVELS-1. Level k holds PW>>k bits, each the OR of an
   // adjacent pair from the level below. These load every cycle; bubbles
   // carry don't-care data that the valid pipe masks at the output stage.
   genvar k;
   for (k = 1; k < LEVELS; k++) begin : g_lvl
      localparam int N = PW >> k;
      logic [2*N-1:0] w_prev;
      logic [N-1:0]   r_data;

      if (k == 1) begin : g_src_in
         assign w_prev = w_pad;
      end else begin : g_src_lvl
         assign w_prev = g_lvl[k-1].r_data;
      end

      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the values present before the edge.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_data <= '0;
         end else begin
            for (int j = 0; j < N; j++) begin
               r_data[j] <= w_prev[2*j] | w_prev[2*j+1];
            end
         end
      end
   end

   // Final pair feeding the output stage: straight from the padded input when
   // the tree has a single level, otherwise from the last registered level.
   logic [1:0] w_pair;
   if (LEVELS == 1) begin : g_pair_in
      assign w_pair = w_pad;
   end else begin : g_pair_lvl
      assign w_pair = g_lvl[LEVELS-1].r_data;
   end

   logic w_final;
   assign w_final = w_pair[0] | w_pair[1];

   // Valid pipe: bit 1 loads in_valid, bit LEVELS is out_valid. w_vld_last is
   // the valid flag travelling with w_pair into the output stage.
   logic [LEVELS:1] r_vld;
   logic            w_vld_last;

   if (LEVELS == 1) begin : g_vld_one
      assign w_vld_last = in_valid;
      always_ff @(posedge clk or posedge rst) begin
         if (rst) r_vld <= '0;
         else     r_vld <= in_valid;
      end
   end else begin : g_vld_multi
      assign w_vld_last = r_vld[LEVELS-1];
      always_ff @(posedge clk or posedge rst) begin
         if (rst) r_vld <= '0;
         else     r_vld <= {r_vld[LEVELS-1:1], in_valid};
      end
   end

   // Output stage. sticky and clr are sampled here, not carried with the
   // data. clr discards a same-cycle result but out_valid still pulses.
   logic r_o;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_o <= 1'b0;
      end else if (clr) begin
         r_o <= 1'b0;
      end else if (w_vld_last) begin
         r_o <= sticky ? (r_o | w_final) : w_final;
      end
   end

   assign o         = r_o;
   assign out_valid = r_vld[LEVELS];

endmodule

// File: tb/tb_or_n_way_pipe.sv
// -----------------------------------------------------------------------------
// tb_or_n_way_pipe
//   Drives three instances (WIDTH = 8, 9, 2) from one directed sequence.
//   Every word sent is pushed to a per-instance queue with its due cycle and
//   its expected OR; each cycle the bench pops arrivals, updates a small model
//   of the output register (clr / sticky) and compares o and out_valid.
// -----------------------------------------------------------------------------
module tb_or_n_way_pipe;

   typedef struct {
      int   due;
      logic res;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       inv   [3];
   logic       stk   [3];
   logic       clr_a [3];
   logic [8:0] dat   [3];
   logic       o_a   [3];
   logic       ov_a  [3];

   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc   = 0;
   exp_t       sb    [3][$];
   logic       m_o   [3];
   int         lv    [3] = '{3, 4, 1};
   logic [8:0] msk   [3] = '{9'h0FF, 9'h1FF, 9'h003};

   always #5 clk = ~clk;

   or_n_way_pipe #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst(rst), .in_valid(inv[0]), .i(dat[0][7:0]),
      .sticky(stk[0]), .clr(clr_a[0]), .o(o_a[0]), .out_valid(ov_a[0]));

   or_n_way_pipe #(.WIDTH(9)) u_w9 (
      .clk(clk), .rst(rst), .in_valid(inv[1]), .i(dat[1]),
      .sticky(stk[1]), .clr(clr_a[1]), .o(o_a[1]), .out_valid(ov_a[1]));

   or_n_way_pipe #(.WIDTH(2)) u_w2 (
      .clk(clk), .rst(rst), .in_valid(inv[2]), .i(dat[2][1:0]),
      .sticky(stk[2]), .clr(clr_a[2]), .o(o_a[2]), .out_valid(ov_a[2]));

   task automatic chk(input string tag, input logic got, input logic want);
      n_cmp++;
      assert (got === want) else begin
         n_bad++;
         $error("FAIL %s: observed %b expected %b", tag, got, want);
      end
   endtask

   // Present word v to instance d on the next edge and record its result.
   task automatic send(input int d, input logic [8:0] v);
      exp_t e;
      inv[d] = 1'b1;
      dat[d] = v;
      e.due  = cyc + lv[d];
      e.res  = |(v & msk[d]);
      sb[d].push_back(e);
   endtask

   // One clock: sample #1 after the edge, settle arrivals against the model,
   // then return single-cycle inputs to idle.
   task automatic step();
      exp_t e;
      logic arrive;
      @(posedge clk);
      #1;
      cyc++;
      for (int d = 0; d < 3; d++) begin
         arrive = 1'b0;
         if (sb[d].size() != 0 && sb[d][0].due == cyc) begin
            arrive = 1'b1;
            e = sb[d].pop_front();
         end
         if (rst || clr_a[d])  m_o[d] = 1'b0;
         else if (arrive)      m_o[d] = stk[d] ? (m_o[d] | e.res) : e.res;
         chk($sformatf("out_valid[w%0d]@%0d", lv[d], cyc), ov_a[d], arrive);
         chk($sformatf("o[w%0d]@%0d", lv[d], cyc), o_a[d], m_o[d]);
         inv[d]   = 1'b0;
         clr_a[d] = 1'b0;
         dat[d]   = '0;
      end
   endtask

   task automatic drain(input int n);
      repeat (n) step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [8:0] v;
      rst = 1'b1;
      for (int d = 0; d < 3; d++) begin
         inv[d] = 1'b0; stk[d] = 1'b0; clr_a[d] = 1'b0; dat[d] = '0; m_o[d] = 1'b0;
      end

      // Reset state.
      drain(2);
      rst = 1'b0;
      cyc = 0;

      // 8'h00 then 8'h10: out_valid on consecutive cycles, o = 0 then 1.
      send(0, 9'h000); step();
      send(0, 9'h010); step();
      drain(4);

      // One-hot walk, then zero.
      for (int k = 0; k < 8; k++) begin
         send(0, 9'(1 << k));
         step();
      end
      send(0, 9'h000); step();
      drain(4);

      // Exhaustive 8-bit sweep, mirrored into the 9- and 2-bit instances.
      for (int n = 0; n < 256; n++) begin
         v = 9'(n);
         send(0, v);
         send(1, {v[0], v[7:0]});
         send(2, v);
         step();
      end
      drain(5);

      // Padding cases on the odd and minimum widths.
      send(1, 9'h100); send(2, 9'h002); step();
      drain(5);
      send(1, 9'h000); send(2, 9'h000); step();
      drain(5);

      // Sticky accumulate, then clear.
      stk[0] = 1'b1;
      send(0, 9'h000); step();
      send(0, 9'h004); step();
      send(0, 9'h000); step();
      drain(4);
      clr_a[0] = 1'b1; step();
      send(0, 9'h000); step();
      drain(4);

      // clr on the same edge that 8'hFF arrives: o reads 0, out_valid pulses.
      send(0, 9'h004); step();
      send(0, 9'h0FF); step();
      step();
      clr_a[0] = 1'b1; step();
      send(0, 9'h000); step();
      drain(4);
      stk[0] = 1'b0;
      step();

      // Asynchronous reset with words in flight.
      for (int n = 0; n < 6; n++) begin
         send(0, 9'h0FF); send(1, 9'h100); send(2, 9'h002);
         step();
      end
      #3;
      rst = 1'b1;
      #1;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("async_rst_o[w%0d]", lv[d]), o_a[d], 1'b0);
         chk($sformatf("async_rst_ov[w%0d]", lv[d]), ov_a[d], 1'b0);
         sb[d].delete();
         m_o[d] = 1'b0;
      end
      drain(2);
      rst = 1'b0;
      // First edge after release accepts a word; nothing else may appear.
      send(0, 9'h001); step();
      drain(6);

      for (int d = 0; d < 3; d++) begin
         chk($sformatf("scoreboard_empty[w%0d]", lv[d]), sb[d].size() == 0, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
